// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and a level interrupt.
// Define TIMER_MODE1_EN to enable auto-reload (MODE=01); otherwise MODE bits are forced to 00.
module timer_counter #(
  parameter logic [31:0] INIT_PRESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  ctrl_reg, ctrl_next;
  logic [31:0] preset_reg, preset_next;
  logic [31:0] count_reg, count_next;
  logic        int_flag_reg, int_flag_next;

  logic        ctrl_wr;
  logic        preset_wr;
  logic [3:0]  ctrl_wdata;
  logic        en_eff;
  logic        auto_reload;
  logic        unused_addr;

  assign ctrl_wr     = we && (addr[3:2] == 2'd0);
  assign preset_wr   = we && (addr[3:2] == 2'd1);
  assign unused_addr = ^addr[31:4];

`ifdef TIMER_MODE1_EN
  assign ctrl_wdata  = writedata[3:0];
  assign auto_reload = (ctrl_reg[2:1] == 2'b01);
`else
  assign ctrl_wdata  = {writedata[3], 2'b00, writedata[0]};
  assign auto_reload = 1'b0;
`endif

  // A disabling CTRL write takes effect on the edge that commits it, so LOAD/CNT stop at once.
  assign en_eff = ctrl_wr ? ctrl_wdata[0] : ctrl_reg[0];

  always_comb begin
    state_next    = state_reg;
    ctrl_next     = ctrl_reg;
    preset_next   = preset_reg;
    count_next    = count_reg;
    int_flag_next = int_flag_reg;

    if (ctrl_wr || preset_wr) begin
      int_flag_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (ctrl_reg[0]) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (!en_eff) begin
          state_next = IDLE;
        end else begin
          count_next    = preset_reg;
          int_flag_next = 1'b0;
          state_next    = CNT;
        end
      end
      CNT: begin
        if (!en_eff) begin
          state_next = IDLE;
        end else if (count_reg > 32'd1) begin
          count_next = count_reg - 32'd1;
        end else begin
          count_next    = 32'd0;
          int_flag_next = 1'b1;
          state_next    = INT;
        end
      end
      INT: begin
        // Auto-reload drops the flag here so the pulse lasts exactly one cycle.
        if (auto_reload) begin
          int_flag_next = 1'b0;
          state_next    = LOAD;
        end else begin
          ctrl_next[0] = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // CPU writes override the FSM's own EN clear.
    if (ctrl_wr) begin
      ctrl_next = ctrl_wdata;
    end
    if (preset_wr) begin
      preset_next = writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      ctrl_reg     <= 4'd0;
      preset_reg   <= INIT_PRESET;
      count_reg    <= 32'd0;
      int_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ctrl_reg     <= ctrl_next;
      preset_reg   <= preset_next;
      count_reg    <= count_next;
      int_flag_reg <= int_flag_next;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (addr[3:2])
      2'd0:    readdata = {28'd0, ctrl_reg};
      2'd1:    readdata = preset_reg;
      2'd2:    readdata = count_reg;
      default: readdata = 32'd0;
    endcase
  end

  assign irq = int_flag_reg & ctrl_reg[3];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: register-access vector table, hand-written
// timing sequences, and randomized one-shot runs against an arithmetic timing model.
module tb_timer_counter;

  localparam logic [31:0] INIT_P = 32'h0000_1234;
`ifdef TIMER_MODE1_EN
  localparam bit MODE1 = 1'b1;
`else
  localparam bit MODE1 = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [31:2] addr;
  logic        we;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_counter #(.INIT_PRESET(INIT_P)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .addr(addr),
    .we(we),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Commits one register write on the next rising edge; returns 1 time unit after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we        = 1'b1;
    addr      = {28'($urandom), a};
    writedata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = {28'($urandom), a};
    #1;
    chk(name, readdata, exp);
  endtask

  function automatic logic [31:0] ctrl_val(input logic im, input logic [1:0] mode, input logic en);
    return {28'd0, im, (MODE1 ? mode : 2'b00), en};
  endfunction

  initial begin
    int p, pe, t, im;
    logic [1:0] mode;
    logic [31:0] exp_cnt, model_count;

    reset_n   = 1'b0;
    we        = 1'b0;
    addr      = '0;
    writedata = '0;

    vecs[0] = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h0};
    vecs[1] = '{1'b0, 2'd0, 32'h0,         2'd1, INIT_P};
    vecs[2] = '{1'b0, 2'd0, 32'h0,         2'd2, 32'h0};
    vecs[3] = '{1'b0, 2'd0, 32'h0,         2'd3, 32'h0};
    vecs[4] = '{1'b1, 2'd1, 32'hDEAD_BEEF, 2'd1, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 2'd2, 32'h0000_FFFF, 2'd2, 32'h0};
    vecs[6] = '{1'b1, 2'd3, 32'h1234_5678, 2'd3, 32'h0};
    vecs[7] = '{1'b1, 2'd0, 32'hFFFF_FFFE, 2'd0, (MODE1 ? 32'hE : 32'h8)};
    vecs[8] = '{1'b1, 2'd0, 32'h0,         2'd0, 32'h0};
    vecs[9] = '{1'b1, 2'd1, 32'd5,         2'd1, 32'd5};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Register access table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
      else tick();
      rd_chk($sformatf("vec%0d_read", i), vecs[i].raddr, vecs[i].exp);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, 32'd0);
      $display("vec %0d: we=%0d waddr=%0d wdata=%h raddr=%0d exp=%h", i, vecs[i].we,
               vecs[i].waddr, vecs[i].wdata, vecs[i].raddr, vecs[i].exp);
    end

    // One-shot, PRESET=5, IM=1: irq from edge 7, EN cleared at edge 8
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("oneshot_irq_k%0d", k), {31'd0, irq}, {31'd0, (k >= 7)});
      rd_chk($sformatf("oneshot_ctrl_k%0d", k), 2'd0, (k <= 7) ? 32'h9 : 32'h8);
    end
    rd_chk("oneshot_count_end", 2'd2, 32'd0);
    wr(2'd1, 32'd5);
    chk("oneshot_irq_cleared", {31'd0, irq}, 32'd0);
    $display("seq oneshot P=5 done");

    // Freeze at 60 then re-enable reloads 100
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 42; k++) tick();
    rd_chk("freeze_count_before", 2'd2, 32'd60);
    wr(2'd0, 32'h8);
    repeat (5) tick();
    rd_chk("freeze_count_held", 2'd2, 32'd60);
    chk("freeze_irq", {31'd0, irq}, 32'd0);
    wr(2'd0, 32'h9);
    tick();
    rd_chk("reenable_count_k1", 2'd2, 32'd60);
    tick();
    rd_chk("reenable_count_k2", 2'd2, 32'd100);
    wr(2'd0, 32'h8);
    rd_chk("reenable_stop_count", 2'd2, 32'd100);
    $display("seq freeze/reenable done");

`ifdef TIMER_MODE1_EN
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("reload_irq_k%0d", k), {31'd0, irq},
          {31'd0, (k >= 5 && ((k - 5) % 5) == 0)});
      rd_chk($sformatf("reload_ctrl_k%0d", k), 2'd0, 32'hB);
    end
    wr(2'd0, 32'h0);
    rd_chk("reload_stop_count", 2'd2, 32'd0);
    chk("reload_stop_irq", {31'd0, irq}, 32'd0);
    $display("seq auto-reload P=3 done");
`else
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    rd_chk("mode_forced_ctrl", 2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("forced_irq_k%0d", k), {31'd0, irq}, {31'd0, (k >= 5)});
      rd_chk($sformatf("forced_ctrl_k%0d", k), 2'd0, (k <= 5) ? 32'h9 : 32'h8);
    end
    wr(2'd1, 32'd3);
    chk("forced_irq_cleared", {31'd0, irq}, 32'd0);
    rd_chk("forced_count_end", 2'd2, 32'd0);
    $display("seq forced one-shot P=3 done");
`endif

    // Randomized one-shot runs against the arithmetic model:
    // irq at edge max(P,1)+2, COUNT = P-(k-2) while counting, EN cleared one edge later.
    model_count = 32'd0;
    for (int r = 0; r < 20; r++) begin
      p  = $urandom_range(0, 12);
      im = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0:       mode = 2'b00;
        1:       mode = 2'b10;
        default: mode = 2'b11;
      endcase
      pe = (p == 0) ? 1 : p;
      t  = pe + 2;
      wr(2'd1, 32'(p));
      chk($sformatf("rnd%0d_irq_clr", r), {31'd0, irq}, 32'd0);
      wr(2'd0, {28'd0, im[0], mode, 1'b1});
      for (int k = 1; k <= t + 2; k++) begin
        tick();
        if (k < 2) exp_cnt = model_count;
        else if (k < t) exp_cnt = 32'(p - (k - 2));
        else exp_cnt = 32'd0;
        chk($sformatf("rnd%0d_irq_k%0d", r, k), {31'd0, irq}, {31'd0, (im != 0 && k >= t)});
        rd_chk($sformatf("rnd%0d_count_k%0d", r, k), 2'd2, exp_cnt);
        rd_chk($sformatf("rnd%0d_ctrl_k%0d", r, k), 2'd0, ctrl_val(im[0], mode, (k <= t)));
      end
      model_count = 32'd0;
      $display("rnd %0d: P=%0d IM=%0d MODE=%b irq_edge=%0d", r, p, im, mode, t);
    end

    // Reset mid-count at COUNT=4, then first write accepted on first edge
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) tick();
    rd_chk("rst_count_before", 2'd2, 32'd4);
    reset_n = 1'b0;
    #1;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_ctrl", 2'd0, 32'h0);
    rd_chk("rst_preset", 2'd1, INIT_P);
    rd_chk("rst_count", 2'd2, 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    we        = 1'b1;
    addr      = {28'($urandom), 2'd1};
    writedata = 32'd7;
    @(posedge clk);
    #1;
    we = 1'b0;
    rd_chk("rst_first_write", 2'd1, 32'd7);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("rst_after_irq_%0d", k), {31'd0, irq}, 32'd0);
    end
    rd_chk("rst_after_count", 2'd2, 32'd0);
    rd_chk("rst_after_ctrl", 2'd0, 32'h0);
    $display("seq reset mid-count done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
